// File: rtl/line_segment_sequencer_pkg.sv
// line_draw_pkg: widths shared with the drawer, segment record and sequencer states
package line_draw_pkg;
    localparam int COL_W = 10;
    localparam int ROW_W = 9;
    localparam int COLOR_W = 8;
    typedef struct packed {
        logic [COL_W-1:0]   x0;
        logic [ROW_W-1:0]   y0;
        logic [COL_W-1:0]   x1;
        logic [ROW_W-1:0]   y1;
        logic [COLOR_W-1:0] color;
    } segment_t;
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;
endpackage

// File: rtl/line_segment_sequencer_fifo.sv
// segment_fifo: show-ahead synchronous FIFO of segment records with full/empty flags
module segment_fifo
    import line_draw_pkg::*;
#(
    parameter type T     = segment_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign head  = mem[rd_ptr[AW-1:0]];
    // storage write; contents are don't-care after reset so no reset here
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    // pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk)
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/line_segment_sequencer.sv
// line_segment_sequencer: queues segments, launches the line drawer, arbitrates the frame-buffer write port
module line_segment_sequencer
    import line_draw_pkg::*;
#(
    parameter int COL_BITS   = COL_W,
    parameter int ROW_BITS   = ROW_W,
    parameter int COLOR_BITS = COLOR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  segValid,
    output logic                  segReady,
    input  logic [COL_BITS-1:0]   segX0,
    input  logic [ROW_BITS-1:0]   segY0,
    input  logic [COL_BITS-1:0]   segX1,
    input  logic [ROW_BITS-1:0]   segY1,
    input  logic [COLOR_BITS-1:0] segColor,
    output logic                  lineStart,
    output logic [COL_BITS-1:0]   lineX0,
    output logic [ROW_BITS-1:0]   lineY0,
    output logic [COL_BITS-1:0]   lineX1,
    output logic [ROW_BITS-1:0]   lineY1,
    input  logic                  lineRunning,
    input  logic [COL_BITS-1:0]   lineX,
    input  logic [ROW_BITS-1:0]   lineY,
    input  logic                  lineReqWr,
    output logic                  lineGrantWr,
    input  logic                  plotReq,
    input  logic [COL_BITS-1:0]   plotX,
    input  logic [ROW_BITS-1:0]   plotY,
    input  logic [COLOR_BITS-1:0] plotColor,
    output logic                  plotGrant,
    input  logic                  fbReady,
    output logic                  fbWe,
    output logic [COL_BITS-1:0]   fbX,
    output logic [ROW_BITS-1:0]   fbY,
    output logic [COLOR_BITS-1:0] fbColor,
    output logic                  idle
);
    typedef struct packed {
        logic [COL_BITS-1:0]   x0;
        logic [ROW_BITS-1:0]   y0;
        logic [COL_BITS-1:0]   x1;
        logic [ROW_BITS-1:0]   y1;
        logic [COLOR_BITS-1:0] color;
    } seg_t;

    seg_t   seg_in, head;
    logic   full, empty, pop, last_plot;
    state_t state;

    assign seg_in   = '{x0: segX0, y0: segY0, x1: segX1, y1: segY1, color: segColor};
    assign segReady = !full;
    assign pop      = state == BUSY && !lineRunning;
    assign idle     = empty && state == IDLE && !lineRunning;
    assign lineX0   = head.x0;
    assign lineY0   = head.y0;
    assign lineX1   = head.x1;
    assign lineY1   = head.y1;

    segment_fifo #(.T(seg_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .resetN(resetN),
        .push  (segValid),
        .pop   (pop),
        .din   (seg_in),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // launch sequencing: start pulse only once the drawer is idle, pop after it drops running
    always_ff @(posedge clk)
        if (!resetN) begin
            state     <= IDLE;
            lineStart <= 1'b0;
        end else begin
            lineStart <= state == IDLE && !empty && !lineRunning;
            state     <= state == IDLE   ? (!empty && !lineRunning ? LAUNCH : IDLE) :
                         state == LAUNCH ? BUSY :
                         lineRunning     ? BUSY : IDLE;
        end

    // round-robin: on contention the side not granted most recently wins
    assign lineGrantWr = fbReady && lineReqWr && (!plotReq || last_plot);
    assign plotGrant   = fbReady && plotReq && (!lineReqWr || !last_plot);
    assign fbWe        = lineGrantWr || plotGrant;
    assign fbX         = lineGrantWr ? lineX : plotGrant ? plotX : '0;
    assign fbY         = lineGrantWr ? lineY : plotGrant ? plotY : '0;
    assign fbColor     = lineGrantWr ? head.color : plotGrant ? plotColor : '0;

    // remember the last winner; reset marks plot so the line wins first contention
    always_ff @(posedge clk)
        if (!resetN) last_plot <= 1'b1;
        else if (lineGrantWr) last_plot <= 1'b0;
        else if (plotGrant) last_plot <= 1'b1;
endmodule

// File: tb/tb_line_segment_sequencer.sv
// tb_line_segment_sequencer: Bresenham drawer stand-in, queue-based reference model and directed plus random stimulus
module tb_line_segment_sequencer;
    localparam int CB = 10, RB = 9, KB = 8, DEPTH = 4;

    logic clk = 0, resetN = 0;
    logic segValid = 0, segReady;
    logic [CB-1:0] segX0 = 0, segX1 = 0;
    logic [RB-1:0] segY0 = 0, segY1 = 0;
    logic [KB-1:0] segColor = 0;
    logic lineStart;
    logic [CB-1:0] lineX0, lineX1;
    logic [RB-1:0] lineY0, lineY1;
    logic lineRunning = 0, lineReqWr = 0, lineGrantWr;
    logic [CB-1:0] lineX = 0;
    logic [RB-1:0] lineY = 0;
    logic plotReq = 0, plotGrant;
    logic [CB-1:0] plotX = 0;
    logic [RB-1:0] plotY = 0;
    logic [KB-1:0] plotColor = 0;
    logic fbReady = 1, fbWe, idle;
    logic [CB-1:0] fbX;
    logic [RB-1:0] fbY;
    logic [KB-1:0] fbColor;

    line_segment_sequencer #(.COL_BITS(CB), .ROW_BITS(RB), .COLOR_BITS(KB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetN(resetN), .segValid(segValid), .segReady(segReady),
        .segX0(segX0), .segY0(segY0), .segX1(segX1), .segY1(segY1), .segColor(segColor),
        .lineStart(lineStart), .lineX0(lineX0), .lineY0(lineY0), .lineX1(lineX1), .lineY1(lineY1),
        .lineRunning(lineRunning), .lineX(lineX), .lineY(lineY), .lineReqWr(lineReqWr), .lineGrantWr(lineGrantWr),
        .plotReq(plotReq), .plotX(plotX), .plotY(plotY), .plotColor(plotColor), .plotGrant(plotGrant),
        .fbReady(fbReady), .fbWe(fbWe), .fbX(fbX), .fbY(fbY), .fbColor(fbColor), .idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bresenham drawer: running at the start edge, two setup cycles, one pixel per grant
    int d_setup = 0, ex = 0, ey = 0, err = 0, sx = 0, sy = 0, ddx = 0, ddy = 0;
    always @(posedge clk) begin
        int ax, ay, e2, ne, nx, ny;
        if (lineStart === 1'b1) begin
            ax = lineX1 >= lineX0 ? int'(lineX1) - int'(lineX0) : int'(lineX0) - int'(lineX1);
            ay = lineY1 >= lineY0 ? int'(lineY1) - int'(lineY0) : int'(lineY0) - int'(lineY1);
            lineRunning <= 1; d_setup <= 2; lineReqWr <= 0;
            lineX <= lineX0; lineY <= lineY0; ex <= int'(lineX1); ey <= int'(lineY1);
            ddx <= ax; ddy <= -ay; err <= ax - ay;
            sx <= lineX1 >= lineX0 ? 1 : -1;
            sy <= lineY1 >= lineY0 ? 1 : -1;
        end else if (lineRunning && d_setup > 0) begin
            d_setup <= d_setup - 1;
            if (d_setup == 1) lineReqWr <= 1;
        end else if (lineReqWr && lineGrantWr === 1'b1) begin
            if (int'(lineX) == ex && int'(lineY) == ey) begin
                lineRunning <= 0; lineReqWr <= 0;
            end else begin
                e2 = 2 * err; ne = err; nx = int'(lineX); ny = int'(lineY);
                if (e2 >= ddy) begin ne += ddy; nx += sx; end
                if (e2 <= ddx) begin ne += ddx; ny += sy; end
                err <= ne; lineX <= CB'(nx); lineY <= RB'(ny);
            end
        end
    end

    // frame-buffer readiness: 0 always ready, 1 toggle, 2 random, 3 stalled
    int fb_mode = 0;
    always @(posedge clk)
        fbReady <= fb_mode == 0 ? 1'b1 : fb_mode == 1 ? !fbReady : fb_mode == 2 ? ($urandom_range(3) != 0) : 1'b0;

    // direct plotter: request held until granted, new request drawn at plot_rate percent
    int plot_rate = 0;
    always @(posedge clk)
        if (!plotReq || plotGrant === 1'b1) begin
            plotReq   <= int'($urandom_range(99)) < plot_rate;
            plotX     <= CB'($urandom_range(639));
            plotY     <= RB'($urandom_range(479));
            plotColor <= KB'($urandom_range(255));
        end

    int n_pass = 0, n_tot = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // reference model: segment queue plus launch/in-flight flags and round-robin memory
    typedef struct { int x0, y0, x1, y1, c; } seg_s;
    seg_s q[$];
    bit mv = 0, launched = 0, start_now = 0, last_plot = 1;
    int lw_n = 0, ls_cnt = 0, ls_t = -1, req_t = -1, push_t = 0;
    int lw_x[64], lw_y[64], lw_t[64], ls_x0[16];

    always @(negedge clk) begin
        bit lg, pg, pop_m, both;
        if (mv) begin
            both = lineReqWr && plotReq;
            lg = fbReady && lineReqWr && (!both || last_plot);
            pg = fbReady && plotReq && (!both || !last_plot);
            chk("segReady", segReady, q.size() < DEPTH);
            chk("lineStart", lineStart, start_now);
            chk("idle", idle, q.size() == 0 && !launched && !start_now && !lineRunning);
            chk("lineGrantWr", lineGrantWr, lg);
            chk("plotGrant", plotGrant, pg);
            chk("fbWe", fbWe, lg || pg);
            chk("fbX", fbX, lg ? lineX : pg ? plotX : 0);
            chk("fbY", fbY, lg ? lineY : pg ? plotY : 0);
            if (!lg || q.size() > 0) chk("fbColor", fbColor, lg ? q[0].c : pg ? plotColor : 0);
            if (launched || start_now) begin
                chk("lineX0", lineX0, q[0].x0); chk("lineY0", lineY0, q[0].y0);
                chk("lineX1", lineX1, q[0].x1); chk("lineY1", lineY1, q[0].y1);
            end
            if (lineStart === 1'b1) begin
                if (ls_cnt < 16) ls_x0[ls_cnt] = int'(lineX0);
                if (ls_t < 0) ls_t = cyc;
                ls_cnt++;
            end
            if (lineReqWr && req_t < 0) req_t = cyc;
            if (lineGrantWr === 1'b1) begin
                if (lw_n < 64) begin lw_x[lw_n] = int'(fbX); lw_y[lw_n] = int'(fbY); lw_t[lw_n] = cyc; end
                lw_n++;
            end
            if (resetN) begin
                pop_m = 0;
                if (start_now) begin start_now = 0; launched = 1; end
                else if (launched) begin if (!lineRunning) begin pop_m = 1; launched = 0; end end
                else if (q.size() > 0 && !lineRunning) start_now = 1;
                if (lg) last_plot = 0; else if (pg) last_plot = 1;
                if (segValid && q.size() < DEPTH)
                    q.push_back('{int'(segX0), int'(segY0), int'(segX1), int'(segY1), int'(segColor)});
                if (pop_m) void'(q.pop_front());
            end
        end
        if (!resetN) begin q.delete(); launched = 0; start_now = 0; last_plot = 1; mv = 1; end
    end

    task automatic step(); @(posedge clk); #1; endtask

    task automatic clear_log(); lw_n = 0; ls_cnt = 0; ls_t = -1; req_t = -1; endtask

    task automatic wait_accept(string name);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (segReady) begin ok = 1; push_t = cyc; end
        end
        chk({name, "_accept"}, ok, 1);
        step();
        segValid = 0;
    endtask

    task automatic drive_seg(int x0, int y0, int x1, int y1, int c);
        segX0 = CB'(x0); segY0 = RB'(y0); segX1 = CB'(x1); segY1 = RB'(y1); segColor = KB'(c); segValid = 1;
    endtask

    task automatic push_seg(int x0, int y0, int x1, int y1, int c);
        drive_seg(x0, y0, x1, y1, c);
        wait_accept("push");
    endtask

    task automatic wait_idle(string name);
        bit ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = idle && !plotReq && !lineRunning;
        end
        chk({name, "_idle"}, ok, 1);
        step();
    endtask

    int px[6] = '{0, 1, 2, 3, 4, 5};
    int py[6] = '{0, 0, 1, 1, 2, 2};

    initial begin
        repeat (2) @(posedge clk);
        #1 resetN = 1;
        @(negedge clk);
        chk("rst_segReady", segReady, 1); chk("rst_idle", idle, 1);
        chk("rst_fbWe", fbWe, 0); chk("rst_lineStart", lineStart, 0); chk("rst_fbX", fbX, 0);
        step();

        clear_log();
        push_seg(0, 0, 5, 2, 8'h11);
        wait_idle("t1");
        chk("t1_starts", ls_cnt, 1); chk("t1_writes", lw_n, 6);
        for (int i = 0; i < 6; i++) begin chk("t1_px", lw_x[i], px[i]); chk("t1_py", lw_y[i], py[i]); end
        chk("t1_span", lw_t[5] - lw_t[0], 5);
        chk("t1_start_lat", ls_t - push_t, 2);
        chk("t1_req_lat", req_t - push_t, 5);

        clear_log();
        fb_mode = 3;
        for (int i = 0; i < 4; i++) push_seg(10 + i, i, 12 + i, i + 2, 8'h20 + i);
        drive_seg(14, 4, 16, 6, 8'h24);
        repeat (10) @(negedge clk);
        chk("t2_full_ready", segReady, 0);
        chk("t2_stalled_starts", ls_cnt, 1);
        step();
        fb_mode = 0;
        wait_accept("t2_fifth");
        wait_idle("t2");
        chk("t2_starts", ls_cnt, 5);
        for (int i = 0; i < 5; i++) chk("t2_order", ls_x0[i], 10 + i);

        clear_log();
        plot_rate = 100;
        repeat (5) step();
        push_seg(0, 0, 5, 2, 8'h33);
        for (int i = 0; i < 300 && lw_n < 6; i++) @(negedge clk);
        chk("t3_writes", lw_n, 6);
        chk("t3_span", lw_t[5] - lw_t[0], 10);
        for (int i = 0; i < 6; i++) chk("t3_px", lw_x[i], px[i]);
        step();
        plot_rate = 0;
        wait_idle("t3");

        clear_log();
        fb_mode = 1;
        push_seg(0, 0, 5, 2, 8'h44);
        wait_idle("t4");
        fb_mode = 0;
        chk("t4_writes", lw_n, 6);
        for (int i = 0; i < 6; i++) begin chk("t4_px", lw_x[i], px[i]); chk("t4_py", lw_y[i], py[i]); end
        chk("t4_span", lw_t[5] - lw_t[0], 10);

        clear_log();
        push_seg(0, 0, 9, 3, 8'h55);
        push_seg(2, 2, 4, 4, 8'h66);
        for (int i = 0; i < 200 && lw_n < 3; i++) @(negedge clk);
        step();
        resetN = 0;
        step();
        resetN = 1;
        push_seg(1, 1, 2, 2, 8'h77);
        wait_idle("t5");
        chk("t5_writes", lw_n, 12);
        chk("t5_starts", ls_cnt, 2);
        chk("t5_second_x0", ls_x0[1], 1);

        clear_log();
        push_seg(7, 3, 7, 3, 8'h88);
        wait_idle("t6");
        chk("t6_writes", lw_n, 1); chk("t6_x", lw_x[0], 7); chk("t6_y", lw_y[0], 3); chk("t6_idle", idle, 1);

        fb_mode = 2;
        plot_rate = 30;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(3)) step();
            push_seg($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(255));
        end
        plot_rate = 0;
        fb_mode = 0;
        wait_idle("rand");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_tot);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/line_segment_sequencer.md
# line_segment_sequencer

Sequences line-segment draw commands into the Bresenham line drawer. Segments are buffered in a small FIFO, and each one is launched with a one-cycle start. The segment's endpoints and colour are held stable until the drawer finishes. The block also arbitrates the single frame-buffer write port, round-robin, between the drawer's pixel requests and a direct single-pixel plot requester, and it sits between the command source (CPU/graphics front end) and the frame-buffer memory.

## Interface
Parameters:
- COL_BITS, 10, frame-buffer column address width
- ROW_BITS, 9, frame-buffer row address width
- COLOR_BITS, 8, pixel colour width
- FIFO_DEPTH, 4, segment FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock
- resetN  in  1  reset, synchronous, active-low
- segValid  in  1  segment command offered
- segReady  out  1  FIFO not full; push occurs on segValid&segReady
- segX0/segX1  in  COL_BITS  segment start/end column
- segY0/segY1  in  ROW_BITS  segment start/end row
- segColor  in  COLOR_BITS  segment colour
- lineStart  out  1  one-cycle start pulse to drawer
- lineX0/lineX1  out  COL_BITS  head-of-FIFO endpoints to drawer
- lineY0/lineY1  out  ROW_BITS  head-of-FIFO endpoints to drawer
- lineRunning  in  1  drawer busy
- lineX/lineY  in  COL_BITS/ROW_BITS  drawer current pixel
- lineReqWr  in  1  drawer pixel-write request
- lineGrantWr  out  1  drawer write granted (combinational)
- plotReq  in  1  direct pixel-write request; held until granted
- plotX/plotY/plotColor  in  COL/ROW/COLOR_BITS  direct pixel
- plotGrant  out  1  direct write granted (combinational)
- fbReady  in  1  frame buffer can accept a write this cycle
- fbWe  out  1  frame-buffer write enable
- fbX/fbY/fbColor  out  COL/ROW/COLOR_BITS  write address/data
- idle  out  1  FIFO empty, FSM IDLE, and lineRunning low

## Operation
- FSM states:
  - IDLE: moves to LAUNCH when the FIFO is non-empty and lineRunning=0.
  - LAUNCH: lineStart=1 for exactly one cycle, then → BUSY.
  - BUSY: when lineRunning=0, pop the FIFO head and → IDLE.
- In LAUNCH the drawer registers running=1 at the same edge, so BUSY never sees a stale low.
- lineX0..lineY1 and the drawing colour are taken directly from the FIFO head. They are stable from LAUNCH through the pop.
- Arbitration:
  - No grant while fbReady=0.
  - With a single requester, that requester is granted.
  - If both request, the winner is the one not granted most recently. A 1-bit lastGrant register updates on every grant.
  - At most one grant per cycle.
- fbWe = lineGrantWr | plotGrant.
- Write data mux:
  - Line grant: fbX/fbY = lineX/lineY, fbColor = head colour.
  - Plot grant: fbX/fbY/fbColor = plotX/plotY/plotColor.
  - Otherwise all zero.
- Drawer grants are issued in any FSM state, so a draw in progress always completes.
- FIFO boundary rules:
  - Full: segReady=0 and no push.
  - Push and pop in the same cycle when non-empty: occupancy unchanged.
  - Empty: no bypass; a push and a launch do not happen in the same cycle.

## Timing
- Reset values: segReady=1, lineStart=0, lineGrantWr=0, plotGrant=0, fbWe=0, fbX/fbY/fbColor=0, idle=1 (if lineRunning=0). lastGrant favours line on the first contention.
- Reset also sets FSM=IDLE and FIFO empty; FIFO contents are don't-care.
- Reset mid-draw: the drawer has no reset and keeps running. The sequencer stays in IDLE until lineRunning=0 and still grants drawer writes, so the interrupted segment completes and a queued segment never overlaps it.
- Latency from a push into an empty FIFO with the drawer idle:
  - Cycle n: push.
  - n+1: IDLE sees non-empty.
  - n+2: lineStart.
  - n+5: first lineReqWr (drawer has 2-cycle setup).
- Grants are combinational on request and fbReady; the frame buffer samples fbWe/fbX/fbY/fbColor at the next clk edge.

## Structure
- Package line_draw_pkg:
  - typedef struct segment_t {x0, y0, x1, y1, color}.
  - FSM enum {IDLE, LAUNCH, BUSY}.
  - Width localparams shared with the drawer.
- Sub-module segment_fifo: synchronous FIFO of segment_t, FIFO_DEPTH entries, with full/empty flags and a head output (show-ahead).
- Arbiter and FSM live in the top module.

## Test plan
- Push one segment (0,0)→(5,2), no plot traffic, fbReady=1 → one lineStart pulse, then 6 fbWe writes in 6 consecutive cycles ending at (5,2), then idle=1.
- Push 5 segments back-to-back with the drawer stalled (FIFO_DEPTH=4) → segReady low after the 4th push; the 5th push is accepted only after the first pop; segments are drawn in order.
- Plot and line both requesting continuously, fbReady=1 → grants alternate line, plot, line, …; the line segment takes twice as many cycles as without plot traffic.
- fbReady toggled 1,0,1,0 during a draw → no grant and no fbWe in fbReady=0 cycles; pixel sequence unchanged.
- Assert resetN=0 for one cycle mid-segment with a second segment queued → FIFO cleared; the first segment still completes; no lineStart until lineRunning=0.
- Push (7,3)→(7,3) (single-pixel segment) → exactly one write at (7,3), pop, idle=1.
